// File: rtl/map_latch_gen_pkg.sv
// Shared definitions for the discrete-latch mapper family: save-state
// register indices, latch-source encodings and the write-filter states.
package map_latch_gen_pkg;

    // Save-state register indices
    localparam logic [7:0] SS_LAT   = 8'd0;
    localparam logic [7:0] SS_OUTER = 8'd1;
    localparam logic [7:0] SS_FILT  = 8'd2;
    localparam logic [7:0] SS_IDX   = 8'd127;

    // Readback value for unimplemented save-state indices
    localparam logic [7:0] SS_EMPTY = 8'hFF;

    // Latch source selection
    localparam int LSRC_ADDR = 0;
    localparam int LSRC_DATA = 1;

    // Read-modify-write filter: ARMED means the previous M2 cycle was a ROM write
    typedef enum logic {
        FILT_IDLE  = 1'b0,
        FILT_ARMED = 1'b1
    } filt_state_e;

endpackage : map_latch_gen_pkg

// File: rtl/map_wr_filter.sv
// Read-modify-write double-write filter. A 6502 RMW instruction writes the
// same address twice on consecutive cycles; only the first of a back-to-back
// run of ROM writes is accepted. The state can be loaded for save states.
module map_wr_filter
    import map_latch_gen_pkg::*;
#(
    parameter int WR_FILTER = 1
) (
    input  logic m2,
    input  logic map_rst,
    input  logic rom_wr,
    input  logic ss_load,
    input  logic ss_val,
    output logic accept,
    output logic wr_prev
);

    filt_state_e state_q, state_d;

    // State register, updated on the M2 falling edge
    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            state_q <= FILT_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            state_q <= state_d;
        end
    end

    // Next state: track the previous cycle, or take the save-state value
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = rom_wr ? FILT_ARMED : FILT_IDLE;
        accept  = 1'b0;
        if (ss_load) begin
            state_d = ss_val ? FILT_ARMED : FILT_IDLE;
        end
        if (rom_wr && !((WR_FILTER != 0) && (state_q == FILT_ARMED))) begin
            accept = 1'b1;
        end
    end

    assign wr_prev = (state_q == FILT_ARMED);

endmodule : map_wr_filter

// File: rtl/map_latch_gen.sv
// Parametrised discrete-latch mapper core: one inner latch feeding PRG/CHR
// bank selection and mirroring, a lockable multicart outer bank, an RMW write
// filter, and full save-state access. All state changes on the M2 falling edge.
module map_latch_gen
    import map_latch_gen_pkg::*;
#(
    parameter int         PRG_BITS     = 4,
    parameter int         CHR_BITS     = 6,
    parameter int         OUTER_BITS   = 2,
    parameter int         LATCH_SRC    = 0,
    parameter int         BUS_CONFLICT = 0,
    parameter int         WR_FILTER    = 1,
    parameter logic [7:0] MAP_IDX      = 8'd201
) (
    input  logic                           m2,
    input  logic                           map_rst,
    input  logic [14:0]                    cpu_addr,
    input  logic [7:0]                     cpu_dat,
    input  logic                           cpu_rw,
    input  logic                           cpu_ce,
    input  logic [7:0]                     rom_dat,
    input  logic                           ss_act,
    input  logic                           ss_we,
    input  logic [7:0]                     ss_addr,
    output logic [OUTER_BITS+PRG_BITS-1:0] prg_bank,
    output logic [OUTER_BITS+CHR_BITS-1:0] chr_bank,
    output logic                           mir_h,
    output logic [7:0]                     ss_rdat
);

    // Outer register keeps at least one bit so it can always be declared;
    // with OUTER_BITS=0 it is held at zero and never reaches an output.
    localparam int OW = (OUTER_BITS > 0) ? OUTER_BITS : 1;

    logic [7:0]    lat_q, lat_d;
    logic [OW-1:0] outer_q, outer_d;
    logic          lock_q, lock_d;

    logic          rom_wr;
    logic          wram_wr;
    logic          accept;
    logic          wr_prev;
    logic          ss_load_filt;
    logic          ss_val_filt;
    logic [7:0]    latch_val;
    logic [OW-1:0] outer_wval;
    logic [6:0]    outer_pad;

    assign rom_wr  = !cpu_ce && !cpu_rw;
    assign wram_wr = cpu_ce && !cpu_rw && (cpu_addr[14:13] == 2'b11);

    // In save-state mode the filter is frozen: it reloads its own value unless
    // the save-state port is writing the filter register.
    assign ss_load_filt = ss_act;
    assign ss_val_filt  = (ss_we && (ss_addr == SS_FILT)) ? cpu_dat[0] : wr_prev;

    map_wr_filter #(
        .WR_FILTER (WR_FILTER)
    ) u_wr_filter (
        .m2      (m2),
        .map_rst (map_rst),
        .rom_wr  (rom_wr),
        .ss_load (ss_load_filt),
        .ss_val  (ss_val_filt),
        .accept  (accept),
        .wr_prev (wr_prev)
    );

    // Value captured into the latch on an accepted ROM write
    always_comb begin
        latch_val = cpu_addr[7:0];
        if (LATCH_SRC == LSRC_DATA) begin
            latch_val = (BUS_CONFLICT != 0) ? (cpu_dat & rom_dat) : cpu_dat;
        end
    end

    // Outer-bank field of a write; zero when there is no outer bank
    always_comb begin
        outer_wval = '0;
        if (OUTER_BITS > 0) begin
            outer_wval = cpu_dat[OW-1:0];
        end
    end

    // Next-state for latch, outer bank and lock: save-state port or bus writes
    always_comb begin
        lat_d   = lat_q;
        outer_d = outer_q;
        lock_d  = lock_q;
        if (ss_act) begin
            if (ss_we) begin
                case (ss_addr)
                    SS_LAT: begin
                        lat_d = cpu_dat;
                    end
                    SS_OUTER: begin
                        outer_d = outer_wval;
                        lock_d  = cpu_dat[7];
                    end
                    default: begin
                    end
                endcase
            end
        end else begin
            if (accept) begin
                lat_d = latch_val;
            end
            if (wram_wr && !lock_q) begin
                outer_d = outer_wval;
                lock_d  = cpu_dat[7];
            end
        end
    end

    // Mapper registers, reset asynchronously, updated on the M2 falling edge
    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            lat_q   <= '0;
            outer_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            lat_q   <= lat_d;
            outer_q <= outer_d;
            lock_q  <= lock_d;
        end
    end

    // Bank outputs are plain concatenations of register slices
    generate
        if (OUTER_BITS > 0) begin : g_outer
            assign prg_bank  = {outer_q, lat_q[PRG_BITS-1:0]};
            assign chr_bank  = {outer_q, lat_q[CHR_BITS-1:0]};
            assign outer_pad = 7'(outer_q);
        end else begin : g_no_outer
            assign prg_bank  = lat_q[PRG_BITS-1:0];
            assign chr_bank  = lat_q[CHR_BITS-1:0];
            assign outer_pad = 7'b0;
        end
    endgenerate

    assign mir_h = lat_q[7];

    // Save-state readback mux
    always_comb begin
        ss_rdat = SS_EMPTY;
        case (ss_addr)
            SS_LAT:   ss_rdat = lat_q;
            SS_OUTER: ss_rdat = {lock_q, outer_pad};
            SS_FILT:  ss_rdat = {7'b0, wr_prev};
            SS_IDX:   ss_rdat = MAP_IDX;
            default:  ss_rdat = SS_EMPTY;
        endcase
    end

    // Bits that are legitimately ignored in some parameterisations
    logic unused_ok;
    assign unused_ok = ^{cpu_addr[12:8], rom_dat, cpu_dat, outer_q};

endmodule : map_latch_gen

// File: tb/tb_map_latch_gen.sv
// Bench for map_latch_gen: two instances (address-sourced latch, and
// data-sourced latch with bus conflicts) driven by the same bus, compared
// against a behavioural model through an expected-response queue.
module tb_map_latch_gen;

    logic        m2 = 1'b0;
    logic        map_rst;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic        cpu_ce;
    logic [7:0]  rom_dat;
    logic        ss_act;
    logic        ss_we;
    logic [7:0]  ss_addr;

    logic [5:0]  prg_a, prg_b;
    logic [7:0]  chr_a, chr_b;
    logic        mir_a, mir_b;
    logic [7:0]  ss_a, ss_b;

    int checks = 0;
    int errors = 0;

    always #10 m2 = ~m2;

    map_latch_gen #(.LATCH_SRC(0), .BUS_CONFLICT(0)) dut_a (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
        .cpu_rw(cpu_rw), .cpu_ce(cpu_ce), .rom_dat(rom_dat), .ss_act(ss_act),
        .ss_we(ss_we), .ss_addr(ss_addr), .prg_bank(prg_a), .chr_bank(chr_a),
        .mir_h(mir_a), .ss_rdat(ss_a)
    );

    map_latch_gen #(.LATCH_SRC(1), .BUS_CONFLICT(1)) dut_b (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
        .cpu_rw(cpu_rw), .cpu_ce(cpu_ce), .rom_dat(rom_dat), .ss_act(ss_act),
        .ss_we(ss_we), .ss_addr(ss_addr), .prg_bank(prg_b), .chr_bank(chr_b),
        .mir_h(mir_b), .ss_rdat(ss_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_lat [2];   // [0] address-sourced, [1] data & rom
    logic [1:0] m_outer;
    logic       m_lock;
    logic       m_prev;

    task automatic model_reset();
        m_lat[0] = 8'h00;
        m_lat[1] = 8'h00;
        m_outer  = 2'b00;
        m_lock   = 1'b0;
        m_prev   = 1'b0;
    endtask

    task automatic model_step(input logic [14:0] a, input logic [7:0] d, input logic rw,
                              input logic ce, input logic [7:0] rom, input logic sa,
                              input logic swe, input logic [7:0] sad);
        logic is_rom_wr, is_wram_wr;
        is_rom_wr  = !ce && !rw;
        is_wram_wr = ce && !rw && (a[14:13] == 2'b11);
        if (sa) begin
            if (swe) begin
                if (sad == 8'd0) begin
                    m_lat[0] = d;
                    m_lat[1] = d;
                end else if (sad == 8'd1) begin
                    m_lock  = d[7];
                    m_outer = d[1:0];
                end else if (sad == 8'd2) begin
                    m_prev = d[0];
                end
            end
        end else begin
            if (is_rom_wr && !m_prev) begin
                m_lat[0] = a[7:0];
                m_lat[1] = d & rom;
            end
            if (is_wram_wr && !m_lock) begin
                m_outer = d[1:0];
                m_lock  = d[7];
            end
            m_prev = is_rom_wr;
        end
    endtask

    function automatic logic [7:0] model_ss(input logic [7:0] lat, input logic [7:0] sad);
        if (sad == 8'd0)   return lat;
        if (sad == 8'd1)   return {m_lock, 5'b0, m_outer};
        if (sad == 8'd2)   return {7'b0, m_prev};
        if (sad == 8'd127) return 8'd201;
        return 8'hFF;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] seq;
        logic        ss_valid;
        logic [5:0]  prg_a;
        logic [7:0]  chr_a;
        logic        mir_a;
        logic [7:0]  ss_a;
        logic [5:0]  prg_b;
        logic [7:0]  chr_b;
        logic        mir_b;
        logic [7:0]  ss_b;
    } exp_t;

    exp_t exp_q[$];
    int   seq_n = 0;

    // One bus cycle: drive just after the rising edge, captured at the falling edge
    task automatic cyc(input logic [14:0] a, input logic [7:0] d, input logic rw, input logic ce,
                       input logic [7:0] rom, input logic sa, input logic swe, input logic [7:0] sad);
        exp_t e;
        @(posedge m2);
        #1;
        cpu_addr = a; cpu_dat = d; cpu_rw = rw; cpu_ce = ce; rom_dat = rom;
        ss_act = sa; ss_we = swe; ss_addr = sad;
        model_step(a, d, rw, ce, rom, sa, swe, sad);
        e.seq      = 16'(seq_n);
        e.ss_valid = sa;
        e.prg_a    = {m_outer, m_lat[0][3:0]};
        e.chr_a    = {m_outer, m_lat[0][5:0]};
        e.mir_a    = m_lat[0][7];
        e.ss_a     = model_ss(m_lat[0], sad);
        e.prg_b    = {m_outer, m_lat[1][3:0]};
        e.chr_b    = {m_outer, m_lat[1][5:0]};
        e.mir_b    = m_lat[1][7];
        e.ss_b     = model_ss(m_lat[1], sad);
        exp_q.push_back(e);
        seq_n++;
    endtask

    // Monitor: at each rising edge the previous cycle's capture is visible
    initial begin
        exp_t e;
        forever begin
            @(posedge m2);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("sb%0d prg_a", e.seq), prg_a, e.prg_a);
                check($sformatf("sb%0d chr_a", e.seq), chr_a, e.chr_a);
                check($sformatf("sb%0d mir_a", e.seq), mir_a, e.mir_a);
                check($sformatf("sb%0d prg_b", e.seq), prg_b, e.prg_b);
                check($sformatf("sb%0d chr_b", e.seq), chr_b, e.chr_b);
                check($sformatf("sb%0d mir_b", e.seq), mir_b, e.mir_b);
                if (e.ss_valid) begin
                    check($sformatf("sb%0d ss_a", e.seq), ss_a, e.ss_a);
                    check($sformatf("sb%0d ss_b", e.seq), ss_b, e.ss_b);
                end
            end
        end
    end

    task automatic settle();
        @(negedge m2);
        #2;
    endtask

    task automatic rom_wr(input logic [14:0] a, input logic [7:0] d, input logic [7:0] rom);
        cyc(a, d, 1'b0, 1'b0, rom, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic idle();
        cyc(15'h0000, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic ss_cyc(input logic swe, input logic [7:0] sad, input logic [7:0] d);
        cyc(15'h0000, d, 1'b1, 1'b1, 8'h00, 1'b1, swe, sad);
    endtask

    // Asynchronous reset in the middle of a cycle, optionally during a save-state write
    task automatic async_reset(input logic sa, input logic swe, input logic [7:0] d);
        @(posedge m2);
        #2;
        cpu_rw = 1'b1; cpu_ce = 1'b1; cpu_addr = '0; cpu_dat = d; rom_dat = 8'h00;
        ss_act = sa; ss_we = swe; ss_addr = 8'd0;
        #2;
        map_rst = 1'b1;
        #1;
        check("rst prg_a", prg_a, 6'h00);
        check("rst chr_a", chr_a, 8'h00);
        check("rst mir_a", mir_a, 1'b0);
        check("rst prg_b", prg_b, 6'h00);
        check("rst chr_b", chr_b, 8'h00);
        check("rst ss_a0", ss_a, 8'h00);
        @(negedge m2);
        #1;
        check("rst dominates ss_a0", ss_a, 8'h00);
        check("rst dominates ss_b0", ss_b, 8'h00);
        ss_act = 1'b0; ss_we = 1'b0;
        map_rst = 1'b0;
        model_reset();
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] a;
        logic [7:0]  d, rom, sad;
        logic        rw, ce, sa, swe;
        int          kind;
        int          wait_n;

        map_rst = 1'b1;
        cpu_addr = '0; cpu_dat = '0; cpu_rw = 1'b1; cpu_ce = 1'b1; rom_dat = '0;
        ss_act = 1'b0; ss_we = 1'b0; ss_addr = 8'd0;
        model_reset();
        #5;
        check("init prg_a", prg_a, 6'h00);
        check("init chr_b", chr_b, 8'h00);
        check("init mir_a", mir_a, 1'b0);
        check("init ss_a0", ss_a, 8'h00);
        #30;
        map_rst = 1'b0;

        // Basic latch: A loads address low byte, B loads cpu_dat & rom_dat
        rom_wr(15'h0025, 8'h0F, 8'h06);
        settle();
        check("w8025 prg_a", prg_a, 6'h05);
        check("w8025 chr_a", chr_a, 8'h25);
        check("w8025 mir_a", mir_a, 1'b0);
        check("busconf prg_b", prg_b, 6'h06);
        idle();
        rom_wr(15'h00A3, 8'h01, 8'hFF);
        settle();
        check("w80A3 prg_a", prg_a, 6'h03);
        check("w80A3 chr_a", chr_a, 8'h23);
        check("w80A3 mir_a", mir_a, 1'b1);
        check("w80A3 prg_b", prg_b, 6'h01);

        // Back-to-back second write is filtered; after a read it is accepted
        rom_wr(15'h0010, 8'h02, 8'hFF);
        settle();
        check("filtered prg_a", prg_a, 6'h03);
        check("filtered prg_b", prg_b, 6'h01);
        idle();
        rom_wr(15'h0010, 8'h02, 8'hFF);
        settle();
        check("spaced prg_b", prg_b, 6'h02);
        check("spaced prg_a", prg_a, 6'h00);

        // Outer bank with lock
        idle();
        rom_wr(15'h0000, 8'h00, 8'h00);
        cyc(15'h6000, 8'h82, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0);
        settle();
        check("outer prg_a", prg_a, 6'h20);
        check("outer chr_a", chr_a, 8'h80);
        cyc(15'h6000, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0);
        settle();
        check("locked prg_a", prg_a, 6'h20);
        check("locked prg_b", prg_b, 6'h20);
        async_reset(1'b0, 1'b0, 8'h00);

        // Save-state write/readback
        ss_cyc(1'b1, 8'd0, 8'h47);
        ss_cyc(1'b1, 8'd1, 8'h81);
        ss_cyc(1'b0, 8'd0, 8'h00);
        settle();
        check("ss rd0", ss_a, 8'h47);
        ss_cyc(1'b0, 8'd1, 8'h00);
        settle();
        check("ss rd1", ss_a, 8'h81);
        ss_cyc(1'b0, 8'd127, 8'h00);
        settle();
        check("ss rd127", ss_b, 8'd201);
        ss_cyc(1'b0, 8'd5, 8'h00);
        settle();
        check("ss rd5", ss_a, 8'hFF);
        cyc(15'h0011, 8'h33, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'd0);
        settle();
        check("ss romwr ss_a0", ss_a, 8'h47);
        check("ss romwr prg_a", prg_a, 6'h17);
        ss_cyc(1'b1, 8'd2, 8'h01);
        settle();
        check("ss rd2", ss_a, 8'h01);
        // Restored ARMED filter swallows the first ROM write after leaving save state
        rom_wr(15'h0055, 8'h55, 8'hFF);
        settle();
        check("restored filt prg_a", prg_a, 6'h17);
        idle();
        rom_wr(15'h0055, 8'h55, 8'hFF);
        settle();
        check("post filt prg_a", prg_a, 6'h15);

        // Reset during a save-state write
        async_reset(1'b1, 1'b1, 8'h5A);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            if ((i % 150) == 149) begin
                async_reset($urandom_range(0, 1) == 1, 1'b1, 8'($urandom));
            end
            a    = 15'($urandom);
            d    = 8'($urandom);
            rom  = 8'($urandom);
            kind = $urandom_range(0, 9);
            rw   = 1'b1;
            ce   = 1'b1;
            if (kind <= 3) begin
                rw = 1'b0; ce = 1'b0;
            end else if (kind <= 5) begin
                rw = 1'b0; a[14:13] = 2'b11;
            end else if (kind == 6) begin
                rw = 1'b0;
            end else if (kind == 9) begin
                ce = 1'b0;
            end
            sa  = ($urandom_range(0, 9) == 0);
            swe = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 4))
                0: sad = 8'd0;
                1: sad = 8'd1;
                2: sad = 8'd2;
                3: sad = 8'd127;
                default: sad = 8'($urandom);
            endcase
            cyc(a, d, rw, ce, rom, sa, swe, sad);
        end

        // Drain the scoreboard, bounded
        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 100) begin
            @(negedge m2);
            wait_n++;
        end
        if (exp_q.size() > 0) begin
            check("scoreboard drain", 32'(exp_q.size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_map_latch_gen

// File: doc/map_latch_gen.md
# map_latch_gen

Parametrised discrete-latch NES mapper core: generalises the single-register address-latch PRG/CHR banking scheme into a configurable latch. It supports:
- address- or data-sourced latching, with optional bus-conflict emulation;
- a lockable multicart outer bank;
- a read-modify-write double-write filter;
- full save-state access.

It sits between the cartridge bus decode and the PRG/CHR address generators. Registers update on the falling edge of `m2`.

## Interface
Parameters:
- `PRG_BITS`, 4: inner PRG bank width (32 KB banks).
- `CHR_BITS`, 6: inner CHR bank width (8 KB banks), must be ≤ 7.
- `OUTER_BITS`, 2: outer multicart bank width, 0..6.
- `LATCH_SRC`, 0: 0 = latch `cpu_addr[7:0]`, 1 = latch `cpu_dat`.
- `BUS_CONFLICT`, 0: 1 = the latched data is `cpu_dat & rom_dat` (only meaningful with `LATCH_SRC`=1).
- `WR_FILTER`, 1: 1 = ignore a ROM write on the cycle directly after a ROM write.
- `MAP_IDX`, 8'd201: value returned at save-state address 127.

Ports:
- `m2`  in  1: CPU M2; the single clock, registers act on its negedge.
- `map_rst`  in  1: reset, asynchronous, active-high.
- `cpu_addr`  in  15: CPU A14..A0.
- `cpu_dat`  in  8: CPU data bus.
- `cpu_rw`  in  1: 1 = read.
- `cpu_ce`  in  1: active low, /ROMSEL ($8000-$FFFF).
- `rom_dat`  in  8: PRG ROM data at the current address (bus conflict).
- `ss_act`  in  1: save-state mode.
- `ss_we`  in  1: save-state write strobe.
- `ss_addr`  in  8: save-state register index.
- `prg_bank`  out  `OUTER_BITS+PRG_BITS`: {outer, inner PRG}.
- `chr_bank`  out  `OUTER_BITS+CHR_BITS`: {outer, inner CHR}.
- `mir_h`  out  1: 1 = horizontal mirroring (latch bit 7).
- `ss_rdat`  out  8: save-state readback, combinational.

## Operation
Registers:
- `lat[7:0]`: inner latch.
- `outer[OUTER_BITS-1:0]`: outer bank.
- `lock`: outer-bank lock.
- `wr_prev`: filter state.

Reset: all registers are 0, so `prg_bank`=0, `chr_bank`=0 and `mir_h`=0.

Decode:
- `rom_wr` = `!cpu_ce & !cpu_rw`.
- `wram_wr` = `cpu_ce & !cpu_rw & cpu_addr[14:13]==2'b11` ($6000-$7FFF).

Filter state machine, two states, IDLE (`wr_prev`=0) and ARMED (`wr_prev`=1):
- Every negedge: `wr_prev` <= `rom_wr`.
- `accept` = `rom_wr & !(WR_FILTER & wr_prev)`.
- A run of N back-to-back ROM writes yields exactly one accepted write: the first.

Latch:
- On `accept`: `lat` <= `LATCH_SRC` ? (`BUS_CONFLICT` ? `cpu_dat & rom_dat` : `cpu_dat`) : `cpu_addr[7:0]`.

Outer bank:
- On `wram_wr & !lock`: `outer` <= `cpu_dat[OUTER_BITS-1:0]`, `lock` <= `cpu_dat[7]`.
- Once `lock`=1, outer writes are ignored until `map_rst`.

Outputs, combinational from the registers:
- `prg_bank` = {`outer`, `lat[PRG_BITS-1:0]`}.
- `chr_bank` = {`outer`, `lat[CHR_BITS-1:0]`}.
- `mir_h` = `lat[7]`.

Save state, while `ss_act`=1:
- Normal writes and `wr_prev` updates are suppressed.
- On negedge with `ss_we`:
  - addr 0: `lat` <= `cpu_dat`.
  - addr 1: {`lock`, `outer`} <= {`cpu_dat[7]`, `cpu_dat[OUTER_BITS-1:0]`}.
  - addr 2: `wr_prev` <= `cpu_dat[0]`.
- `ss_rdat`:
  - addr 0: `lat`.
  - addr 1: {`lock`, zero-padded `outer`}.
  - addr 2: {7'b0, `wr_prev`}.
  - addr 127: `MAP_IDX`.
  - all other addresses: 8'hFF.

`OUTER_BITS`=0: the outer field is absent, `lock` is still stored, and address 1 reads {`lock`, 7'b0}.

## Timing
- A write is captured at the M2 falling edge of the CPU write cycle. The bank outputs change in that cycle and are valid for every access from the next CPU cycle on. Latency is 1 cycle.
- `map_rst` is asynchronous: asserting it forces all registers to 0 immediately, including mid-save-state. Reset dominates `ss_we` and `accept`.
- Simultaneous `rom_wr` and `wram_wr` cannot occur (disjoint decode). `ss_act` with `ss_we`=0 holds all state.
- Bus-conflict AND uses `rom_dat` sampled at the same negedge as `cpu_dat`.
- Arithmetic: none; all fields are truncating slices.

## Structure
- The shared defs include holds:
  - save-state index constants (`SS_LAT`=0, `SS_OUTER`=1, `SS_FILT`=2, `SS_IDX`=127);
  - the `LATCH_SRC` encodings (`LSRC_ADDR`, `LSRC_DATA`).
- Sub-module `map_wr_filter`: owns `wr_prev`. Inputs `m2`, `map_rst`, `rom_wr`, `ss_load`, `ss_val`, `WR_FILTER`; outputs `accept`, `wr_prev`. Reused by later mappers that need RMW filtering.

## Test plan
- Reset, then with `LATCH_SRC`=0 write $8025 → `prg_bank`=5, `chr_bank`=6'h25, `mir_h`=0; then write $80A3 → `prg_bank`=3, `chr_bank`=6'h23, `mir_h`=1.
- `LATCH_SRC`=1, `BUS_CONFLICT`=1: write `cpu_dat`=8'h0F with `rom_dat`=8'h06 → `lat`=8'h06 and `prg_bank` inner=6.
- `WR_FILTER`=1: consecutive writes 8'h01 then 8'h02 → `lat`=1. The same writes separated by one read cycle → `lat`=2.
- Outer lock: $6000←8'h82 → `outer`=2, `lock`=1. Then $6000←8'h01 is ignored (`outer` stays 2, `prg_bank`=8'h20 with inner 0). Then `map_rst` → `outer`=0, `lock`=0.
- Save state: `ss_act`=1, write addr 0 = 8'h47 and addr 1 = 8'h81. Readback addr 0 = 8'h47, addr 1 = 8'h81, addr 127 = `MAP_IDX`, addr 5 = 8'hFF. A ROM write during `ss_act` leaves `lat` unchanged.
- Assert `map_rst` mid save-state write → all outputs 0 with no clock edge; `ss_rdat` at addr 0 = 8'h00.
